// File: rtl/crosswalk_phase_ctrl.sv
// crosswalk_phase_ctrl
// Runs one timed pedestrian phase per walk grant: steady WALK, flashing
// DON'T WALK with a countdown, then an all-red clearance. A grant for the
// other direction arriving mid-phase is queued, and when both directions are
// waiting they are served alternately. All durations are counted in prescaler
// ticks. Every output is a flop loaded from the same next-state values as the
// FSM, so the lamps change on the transition edge and cannot glitch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no phase running; serves the next pending/granted direction
// ST_WALK  | steady WALK for dir_q, WALK_TICKS ticks
// ST_FLASH | flashing DON'T WALK for dir_q with countdown, FLASH_TICKS ticks
// ST_CLEAR | all DON'T WALK clearance, CLEAR_TICKS ticks

module crosswalk_phase_ctrl #(
    parameter int WALK_TICKS  = 7,
    parameter int FLASH_TICKS = 5,
    parameter int CLEAR_TICKS = 2,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          sx,
    input  logic          sy,
    output logic          walk_x,
    output logic          walk_y,
    output logic          dw_x,
    output logic          dw_y,
    output logic [CW-1:0] countdown,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_FLASH = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic DIR_X = 1'b0;
    localparam logic DIR_Y = 1'b1;

    // Counters are loaded with N-1 and the phase ends on the tick seen at zero,
    // giving exactly N ticks after the entry edge.
    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_TICKS - 1);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;

    logic [1:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic          last_dir_q, last_dir_d;
    logic          pend_x_q, pend_x_d;
    logic          pend_y_q, pend_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    logic          walk_x_q, walk_x_d;
    logic          walk_y_q, walk_y_d;
    logic          dw_x_q, dw_x_d;
    logic          dw_y_q, dw_y_d;
    logic [CW-1:0] countdown_q, countdown_d;
    logic          busy_q, busy_d;

    logic          req_x, req_y;
    logic          serve_dir;
    logic          cnt_zero;

    assign req_x    = pend_x_q | sx;
    assign req_y    = pend_y_q | sy;
    assign cnt_zero = (cnt_q == CNT_ZERO);

    // Phase sequencing, pending capture and direction arbitration.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        cnt_d      = cnt_q;
        blink_d    = blink_q;
        serve_dir  = DIR_X;

        case (state_q)
            ST_IDLE: begin
                // Ticks are deliberately ignored here; only requests matter.
                if (req_x || req_y) begin
                    if (req_x && req_y) begin
                        serve_dir = ~last_dir_q;
                    end else begin
                        serve_dir = req_y ? DIR_Y : DIR_X;
                    end
                    state_d    = ST_WALK;
                    dir_d      = serve_dir;
                    last_dir_d = serve_dir;
                    cnt_d      = WALK_LOAD;
                    // A simultaneous request for the unserved side stays queued.
                    pend_x_d   = req_x && (serve_dir == DIR_Y);
                    pend_y_d   = req_y && (serve_dir == DIR_X);
                end
            end

            ST_WALK: begin
                // The running direction's own grant is absorbed while it walks.
                if (sx && (dir_q != DIR_X)) pend_x_d = 1'b1;
                if (sy && (dir_q != DIR_Y)) pend_y_d = 1'b1;
                if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_FLASH;
                        cnt_d   = FLASH_LOAD;
                        blink_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_FLASH: begin
                if (sx && (dir_q != DIR_X)) pend_x_d = 1'b1;
                if (sy && (dir_q != DIR_Y)) pend_y_d = 1'b1;
                if (tick) begin
                    blink_d = ~blink_q;
                    if (cnt_zero) begin
                        state_d = ST_CLEAR;
                        cnt_d   = CLEAR_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_CLEAR: begin
                // Same-direction grants are queued here so a held grant
                // re-serves once clearance has finished.
                if (sx) pend_x_d = 1'b1;
                if (sy) pend_y_d = 1'b1;
                if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so lamps register with the state.
    always_comb begin
        walk_x_d    = (state_d == ST_WALK) && (dir_d == DIR_X);
        walk_y_d    = (state_d == ST_WALK) && (dir_d == DIR_Y);
        dw_x_d      = 1'b1;
        dw_y_d      = 1'b1;
        countdown_d = CNT_ZERO;
        busy_d      = (state_d != ST_IDLE);

        if (walk_x_d) begin
            dw_x_d = 1'b0;
        end else if ((state_d == ST_FLASH) && (dir_d == DIR_X)) begin
            dw_x_d = blink_d;
        end

        if (walk_y_d) begin
            dw_y_d = 1'b0;
        end else if ((state_d == ST_FLASH) && (dir_d == DIR_Y)) begin
            dw_y_d = blink_d;
        end

        if (state_d == ST_FLASH) begin
            countdown_d = cnt_d + CNT_ONE;
        end
    end

    // FSM and datapath registers; reset discards any queued requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_X;
            last_dir_q <= DIR_Y;
            pend_x_q   <= 1'b0;
            pend_y_q   <= 1'b0;
            cnt_q      <= CNT_ZERO;
            blink_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
        end
    end

    // Registered lamp, countdown and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_x_q    <= 1'b0;
            walk_y_q    <= 1'b0;
            dw_x_q      <= 1'b1;
            dw_y_q      <= 1'b1;
            countdown_q <= CNT_ZERO;
            busy_q      <= 1'b0;
        end else begin
            walk_x_q    <= walk_x_d;
            walk_y_q    <= walk_y_d;
            dw_x_q      <= dw_x_d;
            dw_y_q      <= dw_y_d;
            countdown_q <= countdown_d;
            busy_q      <= busy_d;
        end
    end

    assign walk_x    = walk_x_q;
    assign walk_y    = walk_y_q;
    assign dw_x      = dw_x_q;
    assign dw_y      = dw_y_q;
    assign countdown = countdown_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_crosswalk_phase_ctrl.sv
// Directed bench for crosswalk_phase_ctrl with hand-derived phase timing.

module tb_crosswalk_phase_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       sx;
    logic       sy;
    logic       walk_x;
    logic       walk_y;
    logic       dw_x;
    logic       dw_y;
    logic [3:0] countdown;
    logic       busy;

    int n_checks;
    int n_errors;

    crosswalk_phase_ctrl #(
        .WALK_TICKS (7),
        .FLASH_TICKS(5),
        .CLEAR_TICKS(2),
        .CW         (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sx       (sx),
        .sy       (sy),
        .walk_x   (walk_x),
        .walk_y   (walk_y),
        .dw_x     (dw_x),
        .dw_y     (dw_y),
        .countdown(countdown),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input logic t, input logic x, input logic y);
        tick = t;
        sx   = x;
        sy   = y;
        @(posedge clk);
        #1;
        tick = 1'b0;
        sx   = 1'b0;
        sy   = 1'b0;
    endtask

    // Prescaler period: three quiet clocks then a tick clock.
    task automatic tk4(input logic x, input logic y);
        for (int i = 0; i < 3; i++) cyc(1'b0, x, y);
        cyc(1'b1, x, y);
    endtask

    task automatic do_reset();
        tick  = 1'b0;
        sx    = 1'b0;
        sy    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_walk_x", walk_x, 0);
        chk("rst_walk_y", walk_y, 0);
        chk("rst_dw_x", dw_x, 1);
        chk("rst_dw_y", dw_y, 1);
        chk("rst_countdown", countdown, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    // Checks that direction d just entered WALK.
    task automatic chk_walk_entry(input string tag, input logic d);
        chk({tag, "_walk_x"}, walk_x, (d == 1'b0) ? 1 : 0);
        chk({tag, "_walk_y"}, walk_y, (d == 1'b1) ? 1 : 0);
        chk({tag, "_dw_x"}, dw_x, (d == 1'b0) ? 0 : 1);
        chk({tag, "_dw_y"}, dw_y, (d == 1'b1) ? 0 : 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cd"}, countdown, 0);
    endtask

    // Follows a phase for direction d from just after WALK entry to IDLE:
    // 7 WALK ticks, 5 FLASH ticks (countdown 5..1, blink 1,0,1,0,1), 2 CLEAR ticks.
    task automatic run_phase(input string tag, input logic d, input logic hx, input logic hy);
        logic wd, wo, dd, dwo;
        for (int i = 1; i <= 6; i++) begin
            tk4(hx, hy);
            wd = d ? walk_y : walk_x;
            wo = d ? walk_x : walk_y;
            chk({tag, "_walk_hold"}, wd, 1);
            chk({tag, "_walk_other"}, wo, 0);
            chk({tag, "_walk_busy"}, busy, 1);
        end
        for (int k = 0; k < 5; k++) begin
            tk4(hx, hy);
            wd  = d ? walk_y : walk_x;
            wo  = d ? walk_x : walk_y;
            dd  = d ? dw_y : dw_x;
            dwo = d ? dw_x : dw_y;
            chk({tag, "_flash_walk"}, wd, 0);
            chk({tag, "_flash_other_walk"}, wo, 0);
            chk({tag, "_flash_cd"}, countdown, 5 - k);
            chk({tag, "_flash_blink"}, dd, (k % 2 == 0) ? 1 : 0);
            chk({tag, "_flash_other_dw"}, dwo, 1);
        end
        tk4(hx, hy);
        chk({tag, "_clr_cd"}, countdown, 0);
        chk({tag, "_clr_dw_x"}, dw_x, 1);
        chk({tag, "_clr_dw_y"}, dw_y, 1);
        chk({tag, "_clr_walk_x"}, walk_x, 0);
        chk({tag, "_clr_walk_y"}, walk_y, 0);
        chk({tag, "_clr_busy"}, busy, 1);
        tk4(hx, hy);
        chk({tag, "_clr2_busy"}, busy, 1);
        tk4(hx, hy);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_dw_x"}, dw_x, 1);
        chk({tag, "_idle_dw_y"}, dw_y, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tick  = 1'b0;
        sx    = 1'b0;
        sy    = 1'b0;
        rst_n = 1'b1;
        #2;

        // 1: reset and single X grant
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t1_entry", 1'b0);
        run_phase("t1", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_stay_idle", busy, 0);

        // 2: Y grant during X WALK is queued behind the X phase
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t2_entry_x", 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t2_x_unchanged", walk_x, 1);
        chk("t2_y_not_walking", walk_y, 0);
        run_phase("t2x", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_walk_entry("t2_entry_y", 1'b1);
        run_phase("t2y", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_pend_y_cleared", busy, 0);

        // 3: tie alternation from reset: X, then Y; then tie after Y -> X, after X -> Y
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        chk_walk_entry("t3_tie1_x", 1'b0);
        run_phase("t3a", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_walk_entry("t3_queued_y", 1'b1);
        run_phase("t3b", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk_walk_entry("t3_tie2_x", 1'b0);
        run_phase("t3c", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_walk_entry("t3_queued_y2", 1'b1);
        run_phase("t3d", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_idle", busy, 0);
        // last served is Y; a single X grant then a tie must go to Y
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t3_single_x", 1'b0);
        run_phase("t3e", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk_walk_entry("t3_tie3_y", 1'b1);
        run_phase("t3f", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_walk_entry("t3_queued_x", 1'b0);
        run_phase("t3g", 1'b0, 1'b0, 1'b0);

        // 4: held X grant re-serves after one IDLE clock, never Y
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t4_entry", 1'b0);
        run_phase("t4a", 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t4_restart", 1'b0);
        run_phase("t4b", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_done", busy, 0);

        // 5: async reset mid-FLASH at countdown 3, queued Y discarded
        cyc(1'b0, 1'b1, 1'b0);
        chk_walk_entry("t5_entry", 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) tk4(1'b0, 1'b0);
        chk("t5_flash_cd5", countdown, 5);
        tk4(1'b0, 1'b0);
        tk4(1'b0, 1'b0);
        chk("t5_flash_cd3", countdown, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_cd", countdown, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_dw_x", dw_x, 1);
        chk("t5_async_dw_y", dw_y, 1);
        chk("t5_async_walk_x", walk_x, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("t5_no_pending", busy, 0);
            chk("t5_no_walk_y", walk_y, 0);
        end

        // 6: tick on the WALK entry edge is not counted
        cyc(1'b1, 1'b1, 1'b0);
        chk_walk_entry("t6_entry", 1'b0);
        run_phase("t6", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
